program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the number of idle cycles allowed between bytes during a load before abort.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level-sampled load request; honoured only in IDLE, RUN or ERR.
REQ-005 s_valid  input  1  byte-stream valid.
REQ-006 s_data  input  8  byte-stream payload.
REQ-007 s_ready  output  1  byte-stream ready; a byte transfers on an edge where s_valid and s_ready are both 1.
REQ-008 cpu_rst  output  1  active-high hold/load strobe to the 4-bit computer.
REQ-009 ins  output  8  instruction byte presented to the computer.
REQ-010 d_in  output  4  data nibble presented to the computer.
REQ-011 ins_address  output  4  memory address for ins and d_in.
REQ-012 busy  output  1  high in HEADER, INS, DATA, WRITE and RELEASE.
REQ-013 done  output  1  high in RUN.
REQ-014 err  output  1  high in ERR.

Function
REQ-015 Stream format: one header byte, then N records; N = header[3:0]+1 (1..16); header[7:4] is ignored.
- Each record is an instruction byte followed by a data byte.
- Data-byte bits [3:0] form the nibble; bits [7:4] SHALL be 0.
REQ-016 States: IDLE, HEADER, INS, DATA, WRITE, RELEASE, RUN, ERR, all registered.
REQ-017 IDLE/RUN/ERR with start=1 -> HEADER at the next edge.
- cpu_rst=1, err=0, done=0, and the record counter is cleared to 0.
- The byte-accept counter is not modified.
REQ-018 s_ready=1 only in HEADER, INS and DATA; no byte is accepted in any other state, including an edge where start and s_valid coincide.
REQ-019 HEADER accept: latch N -> INS.
- INS accept: latch ins -> DATA.
REQ-020 DATA accept with s_data[7:4]==0: load d_in=s_data[3:0] and ins_address=record counter on the same edge -> WRITE.
REQ-021 DATA accept with s_data[7:4]!=0 -> ERR.
- ins, d_in and ins_address are unchanged.
- cpu_rst stays 1.
REQ-022 WRITE lasts exactly one cycle with cpu_rst=1 and outputs stable, so the computer captures the record on the WRITE-exit edge.
- On that edge the counter increments.
- Next state is INS, or RELEASE when the counter equals N-1.
REQ-023 RELEASE lasts one cycle with cpu_rst=1.
- On the next edge: cpu_rst=0, state RUN.
- Last data byte accepted at edge k gives cpu_rst low after edge k+2.
REQ-024 RUN holds cpu_rst=0 and all outputs constant until start.
- start in RUN re-asserts cpu_rst on the next edge and begins a fresh load.
REQ-025 Timeout: an idle counter is cleared on every accepted byte and on entry to HEADER.
- It increments each cycle in HEADER/INS/DATA without an accept.
- On reaching TIMEOUT -> ERR, cpu_rst held at 1.
REQ-026 N=16 records fill addresses 0..15; the counter SHALL NOT wrap to 0 before RELEASE.
REQ-027 s_valid toggling or s_data changing while s_ready=0 SHALL have no effect.

Reset
REQ-028 While rst=0:
- state=IDLE, cpu_rst=1, s_ready=0, ins=0, d_in=0, ins_address=0, busy=0, done=0, err=0, all counters 0.
REQ-029 Reset asserted mid-load or mid-run takes effect immediately (asynchronously) and leaves the computer held in reset.
- A new start is required after release.

Structure
REQ-030 Shared package program_loader_pkg SHALL hold:
- the state encoding
- the address width (4), instruction width (8) and data width (4)
- the default TIMEOUT
REQ-031 The idle-cycle counter SHALL be a sub-module named loader_timeout, with ports clear, enable and expired, parameterised by TIMEOUT.

Verification
REQ-032 Load, 7 records: start, then stream 06 | 16 00 | 02 03 | 5C 00 | 04 00 | 0F 00 | 05 00 | 0D 00.
- Expect seven WRITE cycles at addresses 0..6 with matching ins/d_in; address 1 carries d_in=3.
- cpu_rst falls two edges after the last byte; done=1.
REQ-033 Full load: header 0F with 16 records, s_valid held 1.
- Expect addresses 0..15 written in order, no wrap, and s_ready low during each WRITE and during RELEASE.
REQ-034 Bad data: third record data byte 0x13.
- Expect err=1, cpu_rst=1 and ins_address=1 held.
- A subsequent start clears err and reloads.
REQ-035 Timeout: with TIMEOUT=8, stop s_valid after the header.
- Expect ERR on the 8th idle cycle, with cpu_rst=1.
REQ-036 Reset mid-load: drop rst during record 3.
- Expect all outputs at reset values immediately, state IDLE after release, and no byte accepted until start.
REQ-037 Restart from RUN: assert start while done=1.
- Expect cpu_rst=1 on the next edge, done=0, and a new load accepted correctly.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types, widths and defaults for the program loader.
package program_loader_pkg;

  localparam int unsigned ADDR_W          = 4;
  localparam int unsigned INS_W           = 8;
  localparam int unsigned DATA_W          = 4;
  localparam int unsigned BYTE_W          = 8;
  // One extra bit so the record counter can pass 15 without wrapping.
  localparam int unsigned CNT_W           = ADDR_W + 1;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_INS,
    ST_DATA,
    ST_WRITE,
    ST_RELEASE,
    ST_RUN,
    ST_ERR
  } state_t;

  // States in which the byte stream is being consumed.
  function automatic logic in_rx(state_t s);
    return (s == ST_HEADER) || (s == ST_INS) || (s == ST_DATA);
  endfunction

  // States that make up an active load sequence.
  function automatic logic in_busy(state_t s);
    return in_rx(s) || (s == ST_WRITE) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter: flags expiry on the TIMEOUT-th consecutive idle cycle.
module loader_timeout
  import program_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Expiry fires on the edge that would complete the TIMEOUT-th idle cycle.
  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

  // Idle counter, cleared on activity, advanced on idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expired ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a header plus instruction/data records into a 4-bit computer's memory.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  output logic              cpu_rst,
  output logic [INS_W-1:0]  ins,
  output logic [DATA_W-1:0] d_in,
  output logic [ADDR_W-1:0] ins_address,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] n_last;
  logic [CNT_W-1:0]  rec_cnt;
  logic              accept;
  logic              launch;
  logic              data_ok;
  logic              last_rec;
  logic              tmo_clear;
  logic              tmo_enable;
  logic              tmo_expired;

  // s_ready is a registered decode of the current state, so it gates transfers directly.
  assign accept     = s_valid && s_ready;
  assign launch     = start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));
  assign data_ok    = (s_data[BYTE_W-1:DATA_W] == '0);
  assign last_rec   = (rec_cnt == CNT_W'(n_last));
  assign tmo_clear  = accept || launch;
  assign tmo_enable = in_rx(state) && !accept;

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_RUN, ST_ERR: if (launch) next_state = ST_HEADER;
      ST_HEADER: begin
        if (accept)           next_state = ST_INS;
        else if (tmo_expired) next_state = ST_ERR;
      end
      ST_INS: begin
        if (accept)           next_state = ST_DATA;
        else if (tmo_expired) next_state = ST_ERR;
      end
      ST_DATA: begin
        if (accept)           next_state = data_ok ? ST_WRITE : ST_ERR;
        else if (tmo_expired) next_state = ST_ERR;
      end
      ST_WRITE:   next_state = last_rec ? ST_RELEASE : ST_INS;
      ST_RELEASE: next_state = ST_RUN;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Registered outputs and record datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready     <= 1'b0;
      cpu_rst     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ins         <= '0;
      d_in        <= '0;
      ins_address <= '0;
      n_last      <= '0;
      rec_cnt     <= '0;
    end else begin
      s_ready <= in_rx(next_state);
      busy    <= in_busy(next_state);
      done    <= (next_state == ST_RUN);
      err     <= (next_state == ST_ERR);
      cpu_rst <= (next_state != ST_RUN);
      if (launch) begin
        rec_cnt <= '0;
      end
      if ((state == ST_HEADER) && accept) begin
        n_last <= s_data[ADDR_W-1:0];
      end
      if ((state == ST_INS) && accept) begin
        ins <= s_data;
      end
      if ((state == ST_DATA) && accept && data_ok) begin
        d_in        <= s_data[DATA_W-1:0];
        ins_address <= rec_cnt[ADDR_W-1:0];
      end
      if (state == ST_WRITE) begin
        rec_cnt <= rec_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a record-level memory model.
module tb_program_loader;

  localparam int unsigned TMO = 8;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       start   = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_ready;
  logic       cpu_rst;
  logic [7:0] ins;
  logic [3:0] d_in;
  logic [3:0] ins_address;
  logic       busy;
  logic       done;
  logic       err;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  logic [7:0] r_ins[16];
  logic [7:0] r_dat[16];

  // Records captured from the computer's point of view.
  int         wa_q[$];
  logic [7:0] wi_q[$];
  logic [3:0] wd_q[$];
  int         nrdy_cnt   = 0;
  logic       prev_ready = 1'b0;

  program_loader #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .cpu_rst    (cpu_rst),
    .ins        (ins),
    .d_in       (d_in),
    .ins_address(ins_address),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // A write cycle is a busy, not-ready cycle straight after a ready cycle.
  always @(negedge clk) begin
    if (busy && !s_ready && prev_ready) begin
      wa_q.push_back(int'(ins_address));
      wi_q.push_back(ins);
      wd_q.push_back(d_in);
    end
    if (busy && !s_ready) nrdy_cnt++;
    prev_ready = s_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired cmp=%0d", cmp_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int gap);
    return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
  endfunction

  // Present one byte; bus noise while not ready, wait bounded. Entered and left at a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit hold);
    int n;
    for (int i = 0; i < gap; i++) begin
      s_valid = s_ready ? 1'b0 : 1'($urandom);
      s_data  = 8'($urandom);
      @(negedge clk);
    end
    n = 0;
    while (!s_ready && n < 64) begin
      s_valid = hold ? 1'b1 : 1'($urandom);
      s_data  = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("send_wait", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    s_valid = hold;
    s_data  = 8'($urandom);
  endtask

  task automatic do_start();
    s_valid = 1'($urandom);
    s_data  = 8'($urandom);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b0;
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("start_done",    32'(done),    32'd0);
    check("start_err",     32'(err),     32'd0);
    check("start_busy",    32'(busy),    32'd1);
    wa_q.delete(); wi_q.delete(); wd_q.delete();
    nrdy_cnt = 0;
  endtask

  task automatic gen_records(input int n);
    for (int i = 0; i < n; i++) begin
      r_ins[i] = 8'($urandom);
      r_dat[i] = {4'h0, 4'($urandom)};
    end
  endtask

  // Full load of r_ins/r_dat[0..n-1] and check of the memory image and release timing.
  task automatic load(input int n, input bit hold, input int gap);
    do_start();
    send_byte({4'($urandom), 4'(n - 1)}, pick(gap), hold);
    for (int i = 0; i < n; i++) begin
      send_byte(r_ins[i], pick(gap), hold);
      send_byte(r_dat[i], pick(gap), hold);
    end
    s_valid = 1'b0;
    check("wr_cpu_rst", 32'(cpu_rst), 32'd1);
    check("wr_ready",   32'(s_ready), 32'd0);
    @(negedge clk);
    check("rel_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rel_busy",    32'(busy),    32'd1);
    @(negedge clk);
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("run_done",    32'(done),    32'd1);
    check("run_busy",    32'(busy),    32'd0);
    check("n_writes",    32'(wa_q.size()), 32'(n));
    check("nrdy_cycles", 32'(nrdy_cnt),    32'(n + 1));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      check($sformatf("wr%0d_addr", i), 32'(wa_q[i]), 32'(i));
      check($sformatf("wr%0d_ins", i),  32'(wi_q[i]), 32'(r_ins[i]));
      check($sformatf("wr%0d_d", i),    32'(wd_q[i]), 32'(r_dat[i][3:0]));
    end
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      @(negedge clk);
      check("run_hold_addr", 32'(ins_address), 32'(n - 1));
      check("run_hold_d",    32'(d_in),        32'(r_dat[n-1][3:0]));
      check("run_hold_done", 32'(done),        32'd1);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d_ins[7];
    logic [7:0] d_dat[7];
    d_ins = '{8'h16, 8'h02, 8'h5C, 8'h04, 8'h0F, 8'h05, 8'h0D};
    d_dat = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset values, with bus noise while held in reset.
    s_valid = 1'b1;
    #12;
    check("rst_cpu_rst", 32'(cpu_rst),     32'd1);
    check("rst_ready",   32'(s_ready),     32'd0);
    check("rst_ins",     32'(ins),         32'd0);
    check("rst_d_in",    32'(d_in),        32'd0);
    check("rst_addr",    32'(ins_address), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_done",    32'(done),        32'd0);
    check("rst_err",     32'(err),         32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      @(negedge clk);
      check("idle_ready", 32'(s_ready), 32'd0);
      check("idle_busy",  32'(busy),    32'd0);
    end
    s_valid = 1'b0;

    // Directed seven-record image.
    for (int i = 0; i < 7; i++) begin
      r_ins[i] = d_ins[i];
      r_dat[i] = d_dat[i];
    end
    load(7, 1'b0, 0);

    // Restarts from RUN with random images and gaps.
    for (int k = 0; k < 5; k++) begin
      int n;
      n = int'($urandom_range(1, 16));
      gen_records(n);
      load(n, 1'($urandom), -1);
    end

    // Longest allowed idle gap between every byte.
    gen_records(2);
    load(2, 1'b0, int'(TMO) - 1);

    // Sixteen records with s_valid held high.
    gen_records(16);
    load(16, 1'b1, 0);

    // Bad data byte in the third record.
    gen_records(3);
    do_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(r_ins[0], 0, 1'b0);
    send_byte(r_dat[0], 0, 1'b0);
    send_byte(r_ins[1], 0, 1'b0);
    send_byte(r_dat[1], 0, 1'b0);
    send_byte(r_ins[2], 0, 1'b0);
    send_byte(8'h13,    0, 1'b0);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bad_err",     32'(err),         32'd1);
      check("bad_cpu_rst", 32'(cpu_rst),     32'd1);
      check("bad_addr",    32'(ins_address), 32'd1);
      check("bad_ins",     32'(ins),         32'(r_ins[2]));
      check("bad_d_in",    32'(d_in),        32'(r_dat[1][3:0]));
      check("bad_ready",   32'(s_ready),     32'd0);
      s_valid = 1'($urandom);
      @(negedge clk);
    end
    check("bad_writes", 32'(wa_q.size()), 32'd2);
    s_valid = 1'b0;
    gen_records(4);
    load(4, 1'b0, -1);

    // Idle timeout after the header.
    do_start();
    send_byte(8'h01, 0, 1'b0);
    s_valid = 1'b0;
    for (int i = 1; i <= int'(TMO) - 1; i++) @(negedge clk);
    check("tmo_before_err", 32'(err),  32'd0);
    check("tmo_before_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_err",     32'(err),     32'd1);
    check("tmo_cpu_rst", 32'(cpu_rst), 32'd1);
    check("tmo_busy",    32'(busy),    32'd0);
    gen_records(2);
    load(2, 1'b0, -1);

    // Asynchronous reset in the middle of record 3.
    gen_records(5);
    do_start();
    send_byte(8'h04, 0, 1'b0);
    send_byte(r_ins[0] | 8'h01, 0, 1'b0);
    send_byte(8'h05, 0, 1'b0);
    send_byte(r_ins[1], 0, 1'b0);
    send_byte(8'h07, 0, 1'b0);
    send_byte(r_ins[2], 0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_cpu_rst", 32'(cpu_rst),     32'd1);
    check("mrst_ready",   32'(s_ready),     32'd0);
    check("mrst_ins",     32'(ins),         32'd0);
    check("mrst_d_in",    32'(d_in),        32'd0);
    check("mrst_addr",    32'(ins_address), 32'd0);
    check("mrst_busy",    32'(busy),        32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      @(negedge clk);
      check("mrst_idle_ready",   32'(s_ready), 32'd0);
      check("mrst_idle_cpu_rst", 32'(cpu_rst), 32'd1);
    end
    s_valid = 1'b0;
    load(5, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
